// File: rtl/pixel_capture_ctrl_pkg.sv
// rtl/pixel_capture_ctrl_pkg.sv - register map, bit positions and FSM encoding for the capture sequencer
package pixel_capture_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_EMPTY     = 3;
    localparam int STAT_FULL      = 4;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTL_START  = 0;
    localparam int CTL_ABORT  = 1;
    localparam int CTL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/pixel_capture_ctrl_fifo.sv
// rtl/pixel_capture_ctrl_fifo.sv - single-clock pixel FIFO with flush and occupancy level
module pixel_fifo #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q;
    logic              push_en, pop_en;

    assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    // A pop frees the slot this cycle, so a push into a full FIFO may proceed alongside it.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_capture_ctrl.sv
// rtl/pixel_capture_ctrl.sv - CPU-armed frame capture of one sensor channel into a register-drained FIFO
module pixel_capture_ctrl
    import pixel_capture_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              frame_sync,
    output logic              irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, remaining_q, remaining_d;
    logic              irq_en_q, done_q, ovf_q;
    logic [31:0]       readdata_q, rd_mux;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    logic wr_status, wr_ctrl, wr_count, start, abort, done_set, ovf_set;

    assign wr_status = write && (address == ADDR_STATUS);
    assign wr_ctrl   = write && (address == ADDR_CTRL);
    assign wr_count  = write && (address == ADDR_COUNT);
    assign start     = wr_ctrl && writedata[CTL_START];
    assign abort     = wr_ctrl && writedata[CTL_ABORT];
    assign fifo_pop  = read && (address == ADDR_DATA) && !fifo_empty;

    pixel_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (pix_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        done_set    = 1'b0;
        ovf_set     = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            fifo_flush  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (count_q != '0)) begin
                        remaining_d = count_q;
                        state_d     = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (frame_sync) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (pix_valid) begin
                        // Dropped pixels still count toward the programmed total.
                        fifo_push   = !fifo_full || fifo_pop;
                        ovf_set     = fifo_full && !fifo_pop;
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = fifo_empty ? 32'd0 : 32'(fifo_head);
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]              = (state_q != S_IDLE);
                rd_mux[STAT_DONE]              = done_q;
                rd_mux[STAT_OVF]               = ovf_q;
                rd_mux[STAT_EMPTY]             = fifo_empty;
                rd_mux[STAT_FULL]              = fifo_full;
                rd_mux[STAT_LEVEL_LSB +: 8]    = 8'(fifo_level);
            end
            ADDR_CTRL:   rd_mux[CTL_IRQ_EN] = irq_en_q;
            ADDR_COUNT:  rd_mux = 32'(count_q);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            if (wr_count) count_q  <= writedata[CNT_W-1:0];
            if (wr_ctrl)  irq_en_q <= writedata[CTL_IRQ_EN];
            // A sticky being set in the same cycle as its clear wins.
            done_q <= done_set || (done_q && !(wr_status && writedata[STAT_DONE]));
            ovf_q  <= ovf_set  || (ovf_q  && !(wr_status && writedata[STAT_OVF]));
            if (read) readdata_q <= rd_mux;
        end
    end

    assign readdata = readdata_q;
    assign irq      = done_q && irq_en_q;

endmodule

// File: tb/tb_pixel_capture_ctrl.sv
// tb/tb_pixel_capture_ctrl.sv - directed self-checking bench for pixel_capture_ctrl
module tb_pixel_capture_ctrl;
    import pixel_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    pixel_capture_ctrl #(.DATA_W(10), .FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .frame_sync (frame_sync),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        chk(tag, readdata, exp);
    endtask

    task automatic pix(input logic [9:0] v);
        pix_data = v; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic fsync();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        rd_chk("rst_status", ADDR_STATUS, 32'h0000_0008);

        // 1: basic 4-pixel capture
        wr(ADDR_COUNT, 32'd4);
        wr(ADDR_CTRL, 32'h1);
        fsync();
        for (int i = 1; i <= 4; i++) pix(10'(i));
        chk("t1_state_done", 32'(dut.state_q), 32'(S_DONE));
        @(negedge clk);
        rd_chk("t1_status", ADDR_STATUS, 32'h0000_0402);
        for (int i = 1; i <= 4; i++) rd_chk("t1_data", ADDR_DATA, 32'(i));
        rd_chk("t1_status_empty", ADDR_STATUS, 32'h0000_000A);
        rd_chk("t1_data_empty", ADDR_DATA, 32'h0);
        wr(ADDR_STATUS, 32'h6);

        // 2: interrupt timing and W1C
        wr(ADDR_CTRL, 32'h4);
        rd_chk("t2_ctrl", ADDR_CTRL, 32'h4);
        wr(ADDR_COUNT, 32'd1);
        wr(ADDR_CTRL, 32'h5);
        fsync();
        pix(10'h3FF);
        chk("t2_irq_in_done", 32'(irq), 32'h0);
        @(negedge clk);
        chk("t2_irq_set", 32'(irq), 32'h1);
        wr(ADDR_STATUS, 32'h2);
        chk("t2_irq_clr", 32'(irq), 32'h0);
        rd_chk("t2_data", ADDR_DATA, 32'h3FF);
        wr(ADDR_CTRL, 32'h0);

        // 3: overflow with COUNT beyond depth
        wr(ADDR_COUNT, 32'd20);
        wr(ADDR_CTRL, 32'h1);
        fsync();
        for (int i = 0; i < 20; i++) pix(10'(32'h100 + i));
        @(negedge clk);
        rd_chk("t3_status", ADDR_STATUS, 32'h0000_1016);
        rd_chk("t3_first", ADDR_DATA, 32'h100);
        wr(ADDR_STATUS, 32'h6);

        // 4: pop and push together while full
        wr(ADDR_COUNT, 32'd2);
        wr(ADDR_CTRL, 32'h1);
        fsync();
        pix(10'h200);
        rd_chk("t4_full", ADDR_STATUS, 32'h0000_1011);
        address = ADDR_DATA; read = 1'b1; pix_data = 10'h201; pix_valid = 1'b1;
        @(negedge clk);
        read = 1'b0; pix_valid = 1'b0;
        chk("t4_pop_head", readdata, 32'h101);
        @(negedge clk);
        rd_chk("t4_status", ADDR_STATUS, 32'h0000_1012);
        for (int i = 2; i < 16; i++) rd_chk("t4_drain", ADDR_DATA, 32'h100 + i);
        rd_chk("t4_tail0", ADDR_DATA, 32'h200);
        rd_chk("t4_tail1", ADDR_DATA, 32'h201);
        wr(ADDR_STATUS, 32'h6);

        // 5: abort mid-capture, then a fresh capture
        wr(ADDR_COUNT, 32'd10);
        wr(ADDR_CTRL, 32'h1);
        fsync();
        for (int i = 0; i < 3; i++) pix(10'(32'h2A0 + i));
        wr(ADDR_CTRL, 32'h3);
        rd_chk("t5_abort_status", ADDR_STATUS, 32'h0000_0008);
        wr(ADDR_CTRL, 32'h1);
        fsync();
        for (int i = 0; i < 10; i++) pix(10'(32'h300 + i));
        @(negedge clk);
        rd_chk("t5_status", ADDR_STATUS, 32'h0000_0A02);
        for (int i = 0; i < 10; i++) rd_chk("t5_data", ADDR_DATA, 32'h300 + i);
        wr(ADDR_CTRL, 32'h4);
        chk("t5_irq", 32'(irq), 32'h1);

        // 6: ignored starts, early pixels, async reset
        wr(ADDR_COUNT, 32'd0);
        wr(ADDR_CTRL, 32'h5);
        rd_chk("t6_zero_count", ADDR_STATUS, 32'h0000_000A);
        wr(ADDR_COUNT, 32'd3);
        wr(ADDR_CTRL, 32'h5);
        pix(10'h055);
        wr(ADDR_CTRL, 32'h5);
        rd_chk("t6_armed", ADDR_STATUS, 32'h0000_000B);
        chk("t6_state_armed", 32'(dut.state_q), 32'(S_ARMED));
        fsync();
        pix(10'h077);
        rd_chk("t6_capture", ADDR_STATUS, 32'h0000_0103);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_readdata", readdata, 32'h0);
        chk("t6_rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_chk("t6_rst_status", ADDR_STATUS, 32'h0000_0008);
        rd_chk("t6_rst_ctrl", ADDR_CTRL, 32'h0);
        rd_chk("t6_rst_count", ADDR_COUNT, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
